// File: rtl/v_seq_exec_pkg.sv
// Shared vector-unit definitions: default geometry, opcode map and sequencer states.
package v_seq_exec_pkg;

    localparam int unsigned DEF_VLEN  = 512;
    localparam int unsigned DEF_ELEN  = 32;
    localparam int unsigned DEF_LANES = 4;
    localparam int unsigned DEF_OP_W  = 8;

    localparam logic [DEF_OP_W-1:0] VADD    = 8'h01;
    localparam logic [DEF_OP_W-1:0] VSUB    = 8'h02;
    localparam logic [DEF_OP_W-1:0] VMUL    = 8'h03;
    localparam logic [DEF_OP_W-1:0] VAND    = 8'h04;
    localparam logic [DEF_OP_W-1:0] VOR     = 8'h05;
    localparam logic [DEF_OP_W-1:0] VXOR    = 8'h06;
    localparam logic [DEF_OP_W-1:0] VSLL    = 8'h07;
    localparam logic [DEF_OP_W-1:0] VSRL    = 8'h08;
    localparam logic [DEF_OP_W-1:0] VSRA    = 8'h09;
    localparam logic [DEF_OP_W-1:0] VMIN    = 8'h0A;
    localparam logic [DEF_OP_W-1:0] VMAX    = 8'h0B;
    localparam logic [DEF_OP_W-1:0] VREDSUM = 8'h10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/v_seq_exec_lane_alu.sv
// Combinational single-element ALU; one instance per lane of the sequenced vector unit.
module v_lane_alu
    import v_seq_exec_pkg::*;
#(
    parameter int unsigned ELEN = DEF_ELEN,
    parameter int unsigned OP_W = DEF_OP_W
) (
    input  logic [OP_W-1:0] op,
    input  logic [ELEN-1:0] a,
    input  logic [ELEN-1:0] b,
    output logic [ELEN-1:0] y,
    output logic            illegal
);

    localparam int unsigned SH_W = $clog2(ELEN);

    logic [SH_W-1:0] shamt;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        y       = '0;
        illegal = 1'b0;
        case (op)
            VADD:    y = a + b;
            VSUB:    y = a - b;
            VMUL:    y = a * b;
            VAND:    y = a & b;
            VOR:     y = a | b;
            VXOR:    y = a ^ b;
            VSLL:    y = a << shamt;
            VSRL:    y = a >> shamt;
            VSRA:    y = $unsigned($signed(a) >>> shamt);
            VMIN:    y = ($signed(a) < $signed(b)) ? a : b;
            VMAX:    y = ($signed(a) < $signed(b)) ? b : a;
            // The reduction consumes the raw vs2 element; summing happens in the sequencer.
            VREDSUM: y = a;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/v_seq_exec.sv
// Multi-cycle vector execution unit: LANES elements per beat, whole-vector result handshake.
module v_seq_exec
    import v_seq_exec_pkg::*;
#(
    parameter int unsigned VLEN  = DEF_VLEN,
    parameter int unsigned ELEN  = DEF_ELEN,
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned OP_W  = DEF_OP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [VLEN-1:0] in_vs1,
    input  logic [VLEN-1:0] in_vs2,
    input  logic [4:0]      in_vd_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [VLEN-1:0] out_data,
    output logic [4:0]      out_vd_addr,
    output logic            out_illegal,
    output logic            busy
);

    localparam int unsigned BEATS = VLEN / (ELEN * LANES);
    localparam int unsigned BW    = $clog2(BEATS + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS);

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [VLEN-1:0] vs1_q, vs1_d;
    logic [VLEN-1:0] vs2_q, vs2_d;
    logic [4:0]      vd_q, vd_d;
    logic [ELEN-1:0] acc_q, acc_d;
    logic [VLEN-1:0] res_q, res_d;
    logic            ill_q, ill_d;

    logic            accept;
    int unsigned     base_idx;
    logic [ELEN-1:0] lane_a [LANES];
    logic [ELEN-1:0] lane_b [LANES];
    logic [ELEN-1:0] lane_y [LANES];
    logic [LANES-1:0] lane_ill;
    logic [ELEN-1:0] red_sum;

    assign accept = in_valid && in_ready;

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // FSM: next state; beat==BEATS is the finalise cycle after the last compute beat
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)              state_d = StRun;
            StRun:   if (beat_q == LAST_BEAT)   state_d = StDone;
            StDone:  if (out_ready)             state_d = StIdle;
            default:                            state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
    end

    assign out_data    = res_q;
    assign out_vd_addr = vd_q;
    assign out_illegal = ill_q;

    // The finalise cycle parks the operand selection on beat 0 to keep indices in range.
    always_comb begin
        base_idx = (beat_q < LAST_BEAT) ? int'(beat_q) * LANES : 0;
        for (int l = 0; l < int'(LANES); l++) begin
            lane_a[l] = vs2_q[(base_idx + l) * ELEN +: ELEN];
            lane_b[l] = vs1_q[(base_idx + l) * ELEN +: ELEN];
        end
    end

    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        v_lane_alu #(
            .ELEN (ELEN),
            .OP_W (OP_W)
        ) u_alu (
            .op      (op_q),
            .a       (lane_a[l]),
            .b       (lane_b[l]),
            .y       (lane_y[l]),
            .illegal (lane_ill[l])
        );
    end

    always_comb begin
        red_sum = acc_q;
        for (int l = 0; l < int'(LANES); l++) begin
            red_sum = red_sum + lane_y[l];
        end
    end

    always_comb begin
        beat_d = beat_q;
        op_d   = op_q;
        vs1_d  = vs1_q;
        vs2_d  = vs2_q;
        vd_d   = vd_q;
        acc_d  = acc_q;
        res_d  = res_q;
        ill_d  = ill_q;
        if (accept) begin
            beat_d = '0;
            op_d   = in_op;
            vs1_d  = in_vs1;
            vs2_d  = in_vs2;
            vd_d   = in_vd_addr;
            acc_d  = in_vs1[ELEN-1:0];
            res_d  = '0;
            ill_d  = 1'b0;
        end else if (state_q == StRun) begin
            if (beat_q == LAST_BEAT) begin
                ill_d = |lane_ill;
                if (op_q == VREDSUM) begin
                    res_d            = '0;
                    res_d[ELEN-1:0]  = acc_q;
                end
            end else begin
                beat_d = beat_q + BW'(1);
                if (op_q == VREDSUM) begin
                    acc_d = red_sum;
                end else begin
                    for (int l = 0; l < int'(LANES); l++) begin
                        res_d[(base_idx + l) * ELEN +: ELEN] = lane_y[l];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q <= '0;
            op_q   <= '0;
            vs1_q  <= '0;
            vs2_q  <= '0;
            vd_q   <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            ill_q  <= 1'b0;
        end else begin
            beat_q <= beat_d;
            op_q   <= op_d;
            vs1_q  <= vs1_d;
            vs2_q  <= vs2_d;
            vd_q   <= vd_d;
            acc_q  <= acc_d;
            res_q  <= res_d;
            ill_q  <= ill_d;
        end
    end

endmodule

// File: tb/tb_v_seq_exec.sv
// Randomised self-checking bench for v_seq_exec against an arithmetic reference model.
module tb_v_seq_exec;
    import v_seq_exec_pkg::*;

    localparam int VLEN = 512;
    localparam int ELEN = 32;
    localparam int NE   = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      in_op = '0;
    logic [VLEN-1:0] in_vs1 = '0;
    logic [VLEN-1:0] in_vs2 = '0;
    logic [4:0]      in_vd_addr = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [VLEN-1:0] out_data;
    logic [4:0]      out_vd_addr;
    logic            out_illegal;
    logic            busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] legal_ops [12] = '{VADD, VSUB, VMUL, VAND, VOR, VXOR, VSLL, VSRL, VSRA,
                                   VMIN, VMAX, VREDSUM};

    always #5 clk = ~clk;

    v_seq_exec dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_vs1      (in_vs1),
        .in_vs2      (in_vs2),
        .in_vd_addr  (in_vd_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_vd_addr (out_vd_addr),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    // Element model in plain 64-bit arithmetic; shifts as multiply/floor-divide by 2^sh.
    function automatic logic [31:0] ref_elem(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] b, output logic bad);
        longint ua, ub, sa, sb, p, r;
        int sh;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        p  = longint'(1) << sh;
        r  = 0;
        bad = 1'b0;
        case (op)
            VADD: r = ua + ub;
            VSUB: r = ua - ub;
            VMUL: r = sa * sb;
            VAND: r = ua & ub;
            VOR:  r = ua | ub;
            VXOR: r = ua ^ ub;
            VSLL: r = ua * p;
            VSRL: r = ua / p;
            VSRA: r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
            VMIN: r = (sa < sb) ? sa : sb;
            VMAX: r = (sa < sb) ? sb : sa;
            default: bad = 1'b1;
        endcase
        return r[31:0];
    endfunction

    function automatic logic [VLEN-1:0] ref_vec(input logic [7:0] op, input logic [VLEN-1:0] v1,
                                                input logic [VLEN-1:0] v2, output logic bad);
        logic [VLEN-1:0] r;
        longint acc;
        logic eb;
        r   = '0;
        bad = 1'b0;
        if (op == VREDSUM) begin
            acc = longint'(v1[31:0]);
            for (int i = 0; i < NE; i++) acc = acc + longint'(v2[i*ELEN +: ELEN]);
            r[31:0] = acc[31:0];
        end else begin
            for (int i = 0; i < NE; i++) begin
                r[i*ELEN +: ELEN] = ref_elem(op, v2[i*ELEN +: ELEN], v1[i*ELEN +: ELEN], eb);
                if (eb) bad = 1'b1;
            end
        end
        if (bad) r = '0;
        return r;
    endfunction

    // Drives one op and observes the result; comparisons are left to the callers.
    task automatic run_op(input logic [7:0] op, input logic [VLEN-1:0] v1,
                          input logic [VLEN-1:0] v2, input logic [4:0] vd,
                          output int lat, output logic [VLEN-1:0] data, output logic ill,
                          output logic [4:0] vdo, output logic busy_ok, output logic rdy_after);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_op = op; in_vs1 = v1; in_vs2 = v2; in_vd_addr = vd; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        data = out_data; ill = out_illegal; vdo = out_vd_addr;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        rdy_after = in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
        n_total++; if (out_vd_addr !== 5'd0) $display("FAIL reset_vd got %h want 0", out_vd_addr); else n_pass++;
        n_total++; if (out_illegal !== 1'b0) $display("FAIL reset_illegal got %b want 0", out_illegal); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_vadd_ramp();
        logic [VLEN-1:0] v1, v2, d, exp;
        logic ill, bok, rdy, eb;
        logic [4:0] vdo;
        int lat;
        for (int i = 0; i < NE; i++) begin
            v1[i*ELEN +: ELEN] = 32'(i);
            v2[i*ELEN +: ELEN] = 32'd100;
        end
        exp = ref_vec(VADD, v1, v2, eb);
        run_op(VADD, v1, v2, 5'd7, lat, d, ill, vdo, bok, rdy);
        n_total++; if (d !== exp) $display("FAIL vadd_data got %h want %h", d, exp); else n_pass++;
        n_total++; if (d[15*ELEN +: ELEN] !== 32'd115) $display("FAIL vadd_elem15 got %h want 115", d[15*ELEN +: ELEN]); else n_pass++;
        n_total++; if (lat !== 5) $display("FAIL vadd_latency got %0d want 5", lat); else n_pass++;
        n_total++; if (bok !== 1'b1) $display("FAIL vadd_busy got %b want 1", bok); else n_pass++;
        n_total++; if (ill !== 1'b0) $display("FAIL vadd_illegal got %b want 0", ill); else n_pass++;
        n_total++; if (vdo !== 5'd7) $display("FAIL vadd_vd got %h want 07", vdo); else n_pass++;
        n_total++; if (rdy !== 1'b1) $display("FAIL vadd_ready_after got %b want 1", rdy); else n_pass++;
    endtask

    task automatic test_boundaries();
        logic [VLEN-1:0] v1, v2, d, exp;
        logic [7:0] ops [5] = '{VADD, VSUB, VSRA, VSRL, VMIN};
        logic [31:0] a_val [5] = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] b_val [5] = '{32'h1, 32'h1, 32'd33, 32'd33, 32'h1};
        logic [31:0] want  [5] = '{32'h0, 32'hFFFFFFFF, 32'hC0000000, 32'h40000000, 32'hFFFFFFFF};
        logic ill, bok, rdy, eb;
        logic [4:0] vdo;
        int lat;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NE; i++) begin
                v1[i*ELEN +: ELEN] = b_val[k];
                v2[i*ELEN +: ELEN] = a_val[k];
            end
            exp = ref_vec(ops[k], v1, v2, eb);
            run_op(ops[k], v1, v2, 5'(k), lat, d, ill, vdo, bok, rdy);
            n_total++; if (d !== exp) $display("FAIL bound_%0d_data got %h want %h", k, d, exp); else n_pass++;
            n_total++; if (d[9*ELEN +: ELEN] !== want[k]) $display("FAIL bound_%0d_elem got %h want %h", k, d[9*ELEN +: ELEN], want[k]); else n_pass++;
        end
    endtask

    task automatic test_redsum();
        logic [VLEN-1:0] v1, v2, d, exp;
        logic ill, bok, rdy, eb;
        logic [4:0] vdo;
        int lat;
        v1 = '0;
        v1[31:0] = 32'd10;
        for (int i = 0; i < NE; i++) v2[i*ELEN +: ELEN] = 32'(i + 1);
        exp = ref_vec(VREDSUM, v1, v2, eb);
        run_op(VREDSUM, v1, v2, 5'd3, lat, d, ill, vdo, bok, rdy);
        n_total++; if (d[31:0] !== 32'd146) $display("FAIL redsum_elem0 got %0d want 146", d[31:0]); else n_pass++;
        n_total++; if (d !== exp) $display("FAIL redsum_data got %h want %h", d, exp); else n_pass++;
        n_total++; if (ill !== 1'b0) $display("FAIL redsum_illegal got %b want 0", ill); else n_pass++;
    endtask

    task automatic test_illegal();
        logic [VLEN-1:0] v1, v2, d;
        logic ill, bok, rdy;
        logic [4:0] vdo;
        int lat;
        for (int i = 0; i < NE; i++) begin
            v1[i*ELEN +: ELEN] = $urandom;
            v2[i*ELEN +: ELEN] = $urandom;
        end
        run_op(8'hFF, v1, v2, 5'd31, lat, d, ill, vdo, bok, rdy);
        n_total++; if (ill !== 1'b1) $display("FAIL illegal_flag got %b want 1", ill); else n_pass++;
        n_total++; if (d !== '0) $display("FAIL illegal_data got %h want 0", d); else n_pass++;
        n_total++; if (lat !== 5) $display("FAIL illegal_latency got %0d want 5", lat); else n_pass++;
        n_total++; if (vdo !== 5'd31) $display("FAIL illegal_vd got %h want 1f", vdo); else n_pass++;
    endtask

    task automatic test_random();
        logic [VLEN-1:0] v1, v2, d, exp;
        logic [7:0] op;
        logic [4:0] vd, vdo;
        logic ill, bok, rdy, eb;
        int lat;
        for (int t = 0; t < 24; t++) begin
            op = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : legal_ops[$urandom_range(0, 11)];
            vd = 5'($urandom);
            for (int i = 0; i < NE; i++) begin
                v1[i*ELEN +: ELEN] = $urandom;
                v2[i*ELEN +: ELEN] = $urandom;
            end
            exp = ref_vec(op, v1, v2, eb);
            run_op(op, v1, v2, vd, lat, d, ill, vdo, bok, rdy);
            n_total++; if (d !== exp) $display("FAIL rand_%0d_op%h_data got %h want %h", t, op, d, exp); else n_pass++;
            n_total++; if (ill !== eb) $display("FAIL rand_%0d_op%h_illegal got %b want %b", t, op, ill, eb); else n_pass++;
            n_total++; if (vdo !== vd) $display("FAIL rand_%0d_vd got %h want %h", t, vdo, vd); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [VLEN-1:0] v1, v2, exp, d0;
        logic [4:0] vd0;
        logic eb, stray;
        int n;
        for (int i = 0; i < NE; i++) begin
            v1[i*ELEN +: ELEN] = $urandom;
            v2[i*ELEN +: ELEN] = $urandom;
        end
        exp = ref_vec(VXOR, v1, v2, eb);
        in_op = VXOR; in_vs1 = v1; in_vs2 = v2; in_vd_addr = 5'd12; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_total++; if (out_data !== exp) $display("FAIL bp_data got %h want %h", out_data, exp); else n_pass++;
        d0 = out_data;
        vd0 = out_vd_addr;
        for (int c = 0; c < 3; c++) begin
            in_valid = (c == 1);
            in_op = VADD; in_vd_addr = 5'd21;
            @(negedge clk);
            n_total++; if (out_valid !== 1'b1) $display("FAIL bp_%0d_valid got %b want 1", c, out_valid); else n_pass++;
            n_total++; if (out_data !== d0 || out_vd_addr !== 5'd12) $display("FAIL bp_%0d_hold got %h/%h want %h/0c", c, out_data, out_vd_addr, d0); else n_pass++;
            n_total++; if (in_ready !== 1'b0) $display("FAIL bp_%0d_in_ready got %b want 0", c, in_ready); else n_pass++;
        end
        in_valid = 1'b0;
        n_total++; if (vd0 !== 5'd12) $display("FAIL bp_vd got %h want 0c", vd0); else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready); else n_pass++;
        stray = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy !== 1'b0 || out_valid !== 1'b0) stray = 1'b1;
        end
        n_total++; if (stray !== 1'b0) $display("FAIL bp_ignored_pulse got activity %b want 0", stray); else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic seen;
        for (int i = 0; i < NE; i++) begin
            in_vs1[i*ELEN +: ELEN] = $urandom;
            in_vs2[i*ELEN +: ELEN] = $urandom;
        end
        in_op = VADD; in_vd_addr = 5'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL midrst_data got %h want 0", out_data); else n_pass++;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL midrst_no_result got %b want 0", seen); else n_pass++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_vadd_ramp();
        test_boundaries();
        test_redsum();
        test_illegal();
        test_random();
        test_backpressure();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/v_seq_exec.md
Name: v_seq_exec

Overview:
- Parametrised, multi-cycle vector execution unit; successor to the single-cycle combinational vector execute stage.
- Accepts one vector op with full-width operands over a valid/ready handshake.
- Processes LANES elements per cycle across VLEN/(ELEN*LANES) beats and returns the whole result vector over a second valid/ready handshake.
- Adds reduction-sum and illegal-op reporting; sits between vector decode and vector write-back in the vector CPU.

Parameters:
- VLEN, 512, vector register width in bits
- ELEN, 32, element width in bits
- LANES, 4, elements processed per cycle; ELEN*LANES must divide VLEN
- OP_W, 8, opcode width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  op presented
- in_ready  out  1  unit can accept an op
- in_op  in  OP_W  opcode
- in_vs1  in  VLEN  operand vs1, element i at bits [i*ELEN +: ELEN]
- in_vs2  in  VLEN  operand vs2, same layout as in_vs1
- in_vd_addr  in  5  destination register tag, passed through
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  VLEN  result vector
- out_vd_addr  out  5  latched destination tag
- out_illegal  out  1  op was not recognised
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, beat=0, result/acc/operand registers=0. Outputs: in_ready=1 after release, out_valid=0, out_data=0, out_vd_addr=0, out_illegal=0, busy=0.
- Define BEATS = VLEN/(ELEN*LANES) and NE = VLEN/ELEN.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch op, vs1, vs2 and vd_addr; clear result and acc; beat=0; go to RUN.
- RUN:
  - in_ready=0. Each cycle, compute elements beat*LANES .. beat*LANES+LANES-1 and write them into the result register.
  - beat increments each cycle; after beat==BEATS-1, go to DONE.
- DONE:
  - out_valid=1; out_data, out_vd_addr and out_illegal hold stable while out_ready=0.
  - On out_ready go to IDLE; in_ready is high the next cycle.
- Latency: handshake at edge T puts out_valid high from edge T+BEATS+1 onward. Throughput is one op per BEATS+2 cycles; there is no overlap.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Elementwise ops (operand a=vs2[i], b=vs1[i]):
  - VADD, VSUB (a-b), VMUL (low ELEN bits of signed product): all mod 2^ELEN.
  - VAND, VOR, VXOR.
  - VSLL, VSRL, VSRA: shift amount = b[log2(ELEN)-1:0].
  - VMIN, VMAX: signed.
- VREDSUM:
  - acc starts at vs1[0]; each beat adds the LANES vs2 elements, mod 2^ELEN.
  - At DONE: element0 = acc, all other elements 0.
- Unknown opcode: runs the full beat sequence, out_data=0, out_illegal=1.
- Reset asserted mid-RUN or mid-DONE: the op is discarded and no out_valid is produced.

Decomposition:
- Shared vector defines package holds:
  - opcode constants: VADD, VSUB, VMUL, VAND, VOR, VXOR, VSLL, VSRL, VSRA, VMIN, VMAX, VREDSUM
  - state encodings
  - default VLEN, ELEN and LANES values
- Sub-module v_lane_alu: combinational single-element ALU (op, a, b -> y, illegal), instantiated LANES times.
- Reduction adder tree and FSM stay in v_seq_exec.

Test Plan (defaults; 16 elements, 4 beats):
- VADD with vs1[i]=i, vs2[i]=100 -> out_data[i]=100+i; out_valid high exactly 5 cycles after the accept edge; busy high throughout.
- VADD with vs2[i]=0xFFFFFFFF, vs1[i]=1 -> all elements 0. VSUB 0-1 -> 0xFFFFFFFF.
- VSRA with vs2[i]=0x80000000, vs1[i]=33 -> 0xC0000000. VSRL with the same inputs -> 0x40000000. VMIN(-1,1) -> 0xFFFFFFFF.
- VREDSUM with vs2[i]=i+1, vs1[0]=10 -> element0=146, elements 1..15=0.
- Backpressure: out_ready=0 for 3 cycles -> out_valid, out_data and out_vd_addr stable, in_ready=0, and an in_valid pulse is ignored. Then out_ready=1 -> in_ready=1 the next cycle.
- Robustness:
  - rst low after 2 RUN beats -> out_valid=0 immediately, in_ready=1 after release, no result emitted.
  - Opcode 0xFF -> out_illegal=1, out_data=0.
